// File: rtl/timer_irq_arbiter_if.sv
// Timer-to-interrupt-controller bundle: match/clear inputs from the timer side, irq handshake to the CPU side.
// The master modport drives events, clears and acknowledges; the slave modport is the arbiter.
interface timer_irq_arbiter_if #(
    parameter int NCH   = 4,
    parameter int VEC_W = 2
);
    logic [NCH-1:0]   match_evt;
    logic [NCH-1:0]   ch_en;
    logic             clr_wr;
    logic [NCH-1:0]   clr_mask;
    logic             irq_ack;
    logic             irq;
    logic [VEC_W-1:0] irq_vec;
    logic [NCH-1:0]   pending;
    logic [NCH-1:0]   overrun;

    modport master (
        output match_evt, ch_en, clr_wr, clr_mask, irq_ack,
        input  irq, irq_vec, pending, overrun
    );

    modport slave (
        input  match_evt, ch_en, clr_wr, clr_mask, irq_ack,
        output irq, irq_vec, pending, overrun
    );
endinterface

// File: rtl/timer_irq_arbiter.sv
// Shares one timer interrupt line between NCH match channels with latched pending/overrun flags.
// Round-robin by default; define TIMER_IRQ_FIXED_PRIO_EN for fixed priority (lowest index wins).
module timer_irq_arbiter #(
    parameter int NCH   = 4,
    parameter int VEC_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    timer_irq_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;

    state_t           state_reg, state_next;
    logic             irq_reg, irq_next;
    logic [VEC_W-1:0] irq_vec_reg, irq_vec_next;
    logic [NCH-1:0]   pending_reg, pending_next;
    logic [NCH-1:0]   overrun_reg, overrun_next;
    logic [NCH-1:0]   set_evt, sw_clr, ack_clr, eligible;
    logic             ack_hit, abort_hit, srv_done;
    logic [VEC_W-1:0] grant_idx;
`ifndef TIMER_IRQ_FIXED_PRIO_EN
    logic [VEC_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [VEC_W-1:0] vec_inc;
`endif

    // Scans start, start+1, ... mod NCH; iterating downwards lets the nearest hit overwrite later ones.
    function automatic logic [VEC_W-1:0] pick_first(input logic [NCH-1:0]   elig,
                                                    input logic [VEC_W-1:0] start);
        logic [VEC_W-1:0] res;
        int               idx;
        res = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % NCH;
            if (elig[idx[VEC_W-1:0]]) res = idx[VEC_W-1:0];
        end
        return res;
    endfunction

    assign set_evt   = bus.match_evt & bus.ch_en;
    assign sw_clr    = bus.clr_wr ? bus.clr_mask : '0;
    assign eligible  = pending_reg & bus.ch_en;
    assign ack_hit   = (state_reg == ASSERT) && bus.irq_ack;
    assign abort_hit = (state_reg == ASSERT) && sw_clr[irq_vec_reg];
    assign srv_done  = ack_hit || abort_hit;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign ack_clr[gi] = ack_hit && (irq_vec_reg == VEC_W'(gi));
            // A coincident match re-arms pending; a software clear also suppresses that cycle's overrun.
            assign pending_next[gi] = set_evt[gi] | (pending_reg[gi] & ~sw_clr[gi] & ~ack_clr[gi]);
            assign overrun_next[gi] = ~sw_clr[gi] & (overrun_reg[gi] | (set_evt[gi] & pending_reg[gi]));
        end
    endgenerate

`ifdef TIMER_IRQ_FIXED_PRIO_EN
    assign grant_idx = pick_first(eligible, '0);
`else
    assign grant_idx = pick_first(eligible, rr_ptr_reg);
    assign vec_inc   = (irq_vec_reg == VEC_W'(NCH - 1)) ? '0 : irq_vec_reg + VEC_W'(1);
`endif

    always_comb begin
        state_next   = state_reg;
        irq_next     = irq_reg;
        irq_vec_next = irq_vec_reg;
`ifndef TIMER_IRQ_FIXED_PRIO_EN
        rr_ptr_next  = rr_ptr_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (|eligible) begin
                    irq_next     = 1'b1;
                    irq_vec_next = grant_idx;
                    state_next   = ASSERT;
                end
            end
            ASSERT: begin
                // Ack, clear-abort, or both together all retire the current request identically.
                if (srv_done) begin
                    irq_next    = 1'b0;
                    state_next  = GAP;
`ifndef TIMER_IRQ_FIXED_PRIO_EN
                    rr_ptr_next = vec_inc;
`endif
                end
            end
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            irq_reg     <= 1'b0;
            irq_vec_reg <= '0;
            pending_reg <= '0;
            overrun_reg <= '0;
`ifndef TIMER_IRQ_FIXED_PRIO_EN
            rr_ptr_reg  <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            irq_reg     <= irq_next;
            irq_vec_reg <= irq_vec_next;
            pending_reg <= pending_next;
            overrun_reg <= overrun_next;
`ifndef TIMER_IRQ_FIXED_PRIO_EN
            rr_ptr_reg  <= rr_ptr_next;
`endif
        end
    end

    assign bus.irq     = irq_reg;
    assign bus.irq_vec = irq_vec_reg;
    assign bus.pending = pending_reg;
    assign bus.overrun = overrun_reg;
endmodule
